// File: rtl/zigzag_ctrl.sv
// -----------------------------------------------------------------------------
// zigzag_ctrl
// Sequencing controller for the 8x8 ZigZag reorder buffer of the JPEG encoder.
// Rows from the DCT/quantiser are accepted over a valid/ready handshake. They
// are forwarded to the ZigZag only while its internal counter is in the load
// phase. The controller mirrors that counter so it can tag the eight reordered
// output words with valid/first/last. It also counts finished blocks and can
// flush the ZigZag.
//
// Optional feature macro: ZIGZAG_CTRL_OVERRUN_EN
//   When defined, this adds input i_out_ready and sticky output o_overrun.
//   It also holds off the row-7 handshake while the consumer is stalled.
//
// Ports:
//   i_clk        clock
//   i_Reset      asynchronous active-low reset
//   i_data       upstream row, 8 coefficients, MSB slot = column 0
//   i_valid      upstream row valid
//   o_ready      a row can be accepted this cycle
//   i_flush      single-cycle abort of the current block
//   i_out_ready  (optional) downstream consumer ready
//   o_overrun    (optional) sticky: a word was output while consumer stalled
//   o_zz_data    row to ZigZag (pass-through of i_data)
//   o_zz_enable  ZigZag write enable (i_valid & o_ready)
//   o_zz_rst_n   ZigZag synchronous active-low reset
//   o_valid      ZigZag output word valid
//   o_first      first word of a block
//   o_last       eighth word of a block
//   o_block_cnt  completed blocks, modulo 2^CNT_W
//   o_busy       block partially loaded or draining
// -----------------------------------------------------------------------------
module zigzag_ctrl #(
    parameter int BW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_Reset,
    input  logic [8*BW-1:0]  i_data,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_flush,
`ifdef ZIGZAG_CTRL_OVERRUN_EN
    input  logic             i_out_ready,
    output logic             o_overrun,
`endif
    output logic [8*BW-1:0]  o_zz_data,
    output logic             o_zz_enable,
    output logic             o_zz_rst_n,
    output logic             o_valid,
    output logic             o_first,
    output logic             o_last,
    output logic [CNT_W-1:0] o_block_cnt,
    output logic             o_busy
);

    logic             r_zz_rst_n;
    logic [3:0]       r_sh;        // shadow of the ZigZag row/word counter
    logic             r_loaded;    // all 8 rows of the current block are in
    logic             r_valid;
    logic             r_first;
    logic             r_last;
    logic [CNT_W-1:0] r_block_cnt;

    logic w_stall;
    logic w_enable;
    logic w_valid_nxt;
    logic w_first_nxt;
    logic w_last_nxt;

`ifdef ZIGZAG_CTRL_OVERRUN_EN
    logic r_overrun;
    // Holding back row 7 keeps a drain from starting into a stalled consumer.
    assign w_stall   = (r_sh == 4'd7) & ~i_out_ready;
    assign o_overrun = r_overrun;
`else
    assign w_stall   = 1'b0;
`endif

    // Flush wins over a simultaneous row, so it also masks ready.
    assign o_ready     = r_zz_rst_n & ~r_sh[3] & ~i_flush & ~w_stall;
    assign w_enable    = i_valid & o_ready;
    assign o_zz_enable = w_enable;
    assign o_zz_data   = i_data;
    assign o_zz_rst_n  = r_zz_rst_n;

    // The flags line up with the ZigZag's registered output word.
    assign w_valid_nxt = r_sh[3] & r_loaded & r_zz_rst_n & ~i_flush;
    assign w_first_nxt = (r_sh == 4'd8)  & r_loaded & ~i_flush;
    assign w_last_nxt  = (r_sh == 4'd15) & r_loaded & ~i_flush;

    assign o_valid     = r_valid;
    assign o_first     = r_first;
    assign o_last      = r_last;
    assign o_block_cnt = r_block_cnt;
    assign o_busy      = r_loaded | ((r_sh != 4'd0) & (r_sh != 4'd15)) | ~r_zz_rst_n;

    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_zz_rst_n  <= 1'b0;
            r_sh        <= 4'hF;
            r_loaded    <= 1'b0;
            r_valid     <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_block_cnt <= '0;
        end else begin
            // A flush pulses the ZigZag reset low for exactly one cycle.
            r_zz_rst_n <= ~i_flush;

            // This must track the ZigZag counter exactly. The ZigZag free-runs
            // through 8..15 and returns to 15 whenever its reset is sampled low.
            if (!r_zz_rst_n)
                r_sh <= 4'hF;
            else if (w_enable || r_sh[3])
                r_sh <= r_sh + 4'd1;

            if (i_flush)
                r_loaded <= 1'b0;
            else if (w_enable && (r_sh == 4'd7))
                r_loaded <= 1'b1;
            else if (r_zz_rst_n && (r_sh == 4'hF))
                r_loaded <= 1'b0;

            r_valid <= w_valid_nxt;
            r_first <= w_first_nxt;
            r_last  <= w_last_nxt;

            if (w_last_nxt)
                r_block_cnt <= r_block_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef ZIGZAG_CTRL_OVERRUN_EN
    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset)
            r_overrun <= 1'b0;
        else if (i_flush)
            r_overrun <= 1'b0;
        else if (r_valid && !i_out_ready)
            r_overrun <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_zigzag_ctrl.sv
module tb_zigzag_ctrl;

    localparam int BW    = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             i_Reset;
    logic [8*BW-1:0]  i_data;
    logic             i_valid;
    logic             o_ready;
    logic             i_flush;
    logic             i_out_ready;
    logic             o_overrun;
    logic [8*BW-1:0]  o_zz_data;
    logic             o_zz_enable;
    logic             o_zz_rst_n;
    logic             o_valid;
    logic             o_first;
    logic             o_last;
    logic [CNT_W-1:0] o_block_cnt;
    logic             o_busy;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_blocks = '0;

    zigzag_ctrl #(.BW(BW), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_Reset     (i_Reset),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_flush     (i_flush),
`ifdef ZIGZAG_CTRL_OVERRUN_EN
        .i_out_ready (i_out_ready),
        .o_overrun   (o_overrun),
`endif
        .o_zz_data   (o_zz_data),
        .o_zz_enable (o_zz_enable),
        .o_zz_rst_n  (o_zz_rst_n),
        .o_valid     (o_valid),
        .o_first     (o_first),
        .o_last      (o_last),
        .o_block_cnt (o_block_cnt),
        .o_busy      (o_busy)
    );

`ifndef ZIGZAG_CTRL_OVERRUN_EN
    assign o_overrun = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Coefficient values 0..63 row-major; column 0 sits in the MSB slot.
    function automatic logic [8*BW-1:0] row_val(input int r);
        logic [8*BW-1:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) v[(7-c)*BW +: BW] = BW'(r*8 + c);
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Offer rows 0..n-1 and wait (bounded) for each handshake. Returns in the
    // cycle of the last handshake.
    task automatic send_rows(input int n, input bit gap);
        int bound;
        for (int r = 0; r < n; r++) begin
            tick();
            i_valid = 1'b1;
            i_data  = row_val(r);
            #1;
            bound = 0;
            while (!o_ready && bound < 40) begin
                tick(); #1; bound++;
            end
            if (o_ready !== 1'b1) begin errors++; $display("FAIL row_ready_timeout r=%0d got %b exp 1", r, o_ready); end
            checks++;
            if (o_zz_enable !== 1'b1) begin errors++; $display("FAIL row_enable r=%0d got %b exp 1", r, o_zz_enable); end
            checks++;
            if (o_zz_data !== row_val(r)) begin errors++; $display("FAIL row_data r=%0d got %h exp %h", r, o_zz_data, row_val(r)); end
            checks++;
            if (gap && r < n-1) begin
                tick();
                i_valid = 1'b0;
                #1;
                if (o_zz_enable !== 1'b0) begin errors++; $display("FAIL gap_enable r=%0d got %b exp 0", r, o_zz_enable); end
                checks++;
            end
        end
    endtask

    // Checks the 10 cycles after the row-7 handshake. With hold set,
    // i_valid stays high through DRAIN.
    task automatic drain_check(input bit hold, input string tag);
        logic [CNT_W-1:0] ec;
        for (int k = 1; k <= 10; k++) begin
            tick();
            i_valid = hold && (k <= 8);
            #1;
            ec = (k >= 9) ? exp_blocks + 1'b1 : exp_blocks;
            if (o_valid !== (k >= 2 && k <= 9)) begin errors++; $display("FAIL %s valid k=%0d got %b", tag, k, o_valid); end
            checks++;
            if (o_first !== (k == 2)) begin errors++; $display("FAIL %s first k=%0d got %b", tag, k, o_first); end
            checks++;
            if (o_last !== (k == 9)) begin errors++; $display("FAIL %s last k=%0d got %b", tag, k, o_last); end
            checks++;
            if (o_ready !== (k >= 9)) begin errors++; $display("FAIL %s ready k=%0d got %b", tag, k, o_ready); end
            checks++;
            if (o_zz_enable !== 1'b0) begin errors++; $display("FAIL %s enable k=%0d got %b exp 0", tag, k, o_zz_enable); end
            checks++;
            if (o_busy !== (k <= 8)) begin errors++; $display("FAIL %s busy k=%0d got %b", tag, k, o_busy); end
            checks++;
            if (o_block_cnt !== ec) begin errors++; $display("FAIL %s block_cnt k=%0d got %0d exp %0d", tag, k, o_block_cnt, ec); end
            checks++;
        end
        exp_blocks = exp_blocks + 1'b1;
    endtask

    task automatic test_reset();
        i_Reset = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_data = '0; i_out_ready = 1'b1;
        tick(); tick(); #1;
        if ({o_zz_rst_n, o_valid, o_first, o_last, o_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {o_zz_rst_n, o_valid, o_first, o_last, o_ready});
        end
        checks++;
        if (o_block_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", o_block_cnt); end
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", o_busy); end
        checks++;
        if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", o_overrun); end
        checks++;
        tick();
        i_Reset = 1'b1;
        #1;
        if (o_zz_rst_n !== 1'b0) begin errors++; $display("FAIL release_rst_n c=0 got %b exp 0", o_zz_rst_n); end
        checks++;
        for (int c = 1; c <= 20; c++) begin
            tick(); #1;
            if (o_zz_rst_n !== 1'b1) begin errors++; $display("FAIL idle_rst_n c=%0d got %b exp 1", c, o_zz_rst_n); end
            checks++;
            if (o_valid !== 1'b0) begin errors++; $display("FAIL idle_valid c=%0d got %b exp 0", c, o_valid); end
            checks++;
            if (o_ready !== (c >= 2)) begin errors++; $display("FAIL idle_ready c=%0d got %b", c, o_ready); end
            checks++;
            if (o_block_cnt !== '0) begin errors++; $display("FAIL idle_cnt c=%0d got %0d exp 0", c, o_block_cnt); end
            checks++;
        end
    endtask

    task automatic test_block();
        send_rows(8, 1'b0);
        drain_check(1'b0, "block");
    endtask

    task automatic test_gaps_hold();
        send_rows(8, 1'b1);
        drain_check(1'b1, "gaps");
    endtask

    task automatic test_back_to_back();
        send_rows(8, 1'b0);
        drain_check(1'b0, "b2b_a");
        send_rows(8, 1'b0);
        drain_check(1'b0, "b2b_b");
    endtask

    task automatic test_flush_load();
        send_rows(5, 1'b0);
        tick();
        i_flush = 1'b1; i_valid = 1'b1; i_data = row_val(5);
        #1;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", o_ready); end
        checks++;
        if (o_zz_enable !== 1'b0) begin errors++; $display("FAIL flush_enable got %b exp 0", o_zz_enable); end
        checks++;
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        #1;
        if (o_zz_rst_n !== 1'b0) begin errors++; $display("FAIL flush_rst_n_low got %b exp 0", o_zz_rst_n); end
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL flush_busy got %b exp 1", o_busy); end
        checks++;
        tick(); #1;
        if (o_zz_rst_n !== 1'b1 || o_ready !== 1'b0) begin
            errors++; $display("FAIL flush_recover got rst_n=%b ready=%b exp 1 0", o_zz_rst_n, o_ready);
        end
        checks++;
        send_rows(8, 1'b0);
        drain_check(1'b0, "after_flush");
    endtask

    task automatic test_flush_drain();
        send_rows(8, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            i_valid = 1'b0;
            i_flush = (k == 4);
            #1;
            if (o_valid !== (k >= 2 && k <= 4)) begin errors++; $display("FAIL fdrain_valid k=%0d got %b", k, o_valid); end
            checks++;
            if (o_last !== 1'b0) begin errors++; $display("FAIL fdrain_last k=%0d got %b exp 0", k, o_last); end
            checks++;
            if (o_block_cnt !== exp_blocks) begin errors++; $display("FAIL fdrain_cnt k=%0d got %0d exp %0d", k, o_block_cnt, exp_blocks); end
            checks++;
            if (k == 5 && o_zz_rst_n !== 1'b0) begin errors++; $display("FAIL fdrain_rst_n got %b exp 0", o_zz_rst_n); end
            if (k == 5) checks++;
            if (k >= 7 && o_ready !== 1'b1) begin errors++; $display("FAIL fdrain_ready k=%0d got %b exp 1", k, o_ready); end
            if (k >= 7) checks++;
        end
        i_flush = 1'b0;
    endtask

`ifdef ZIGZAG_CTRL_OVERRUN_EN
    task automatic test_overrun();
        i_out_ready = 1'b0;
        send_rows(7, 1'b0);
        for (int w = 0; w < 3; w++) begin
            tick();
            i_valid = 1'b1; i_data = row_val(7);
            #1;
            if (o_ready !== 1'b0 || o_zz_enable !== 1'b0) begin
                errors++; $display("FAIL ovr_hold w=%0d got ready=%b en=%b exp 0 0", w, o_ready, o_zz_enable);
            end
            checks++;
        end
        tick();
        i_out_ready = 1'b1;
        #1;
        if (o_zz_enable !== 1'b1) begin errors++; $display("FAIL ovr_release got %b exp 1", o_zz_enable); end
        checks++;
        for (int k = 1; k <= 9; k++) begin
            tick();
            i_valid = 1'b0;
            i_out_ready = (k != 4);
            #1;
            if (o_overrun !== (k >= 5)) begin errors++; $display("FAIL ovr_sticky k=%0d got %b", k, o_overrun); end
            checks++;
        end
        if (o_last !== 1'b1) begin errors++; $display("FAIL ovr_last got %b exp 1", o_last); end
        checks++;
        exp_blocks = exp_blocks + 1'b1;
        tick();
        i_flush = 1'b1;
        #1;
        tick();
        i_flush = 1'b0;
        #1;
        if (o_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", o_overrun); end
        checks++;
        tick(); tick();
    endtask
`endif

    task automatic test_async_reset();
        send_rows(8, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick(); i_valid = 1'b0; #1;
        end
        if (o_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %b exp 1", o_valid); end
        checks++;
        #2;
        i_Reset = 1'b0;
        #1;
        if ({o_valid, o_zz_rst_n, o_ready} !== 3'b000) begin
            errors++; $display("FAIL areset_drop got %b exp 000", {o_valid, o_zz_rst_n, o_ready});
        end
        checks++;
        if (o_block_cnt !== '0) begin errors++; $display("FAIL areset_cnt got %0d exp 0", o_block_cnt); end
        checks++;
        exp_blocks = '0;
        tick();
        i_Reset = 1'b1;
        #1;
        tick(); #1;
        if (o_zz_rst_n !== 1'b1 || o_ready !== 1'b0 || o_valid !== 1'b0) begin
            errors++; $display("FAIL areset_c1 got rst_n=%b ready=%b valid=%b exp 1 0 0", o_zz_rst_n, o_ready, o_valid);
        end
        checks++;
        tick(); #1;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL areset_c2_ready got %b exp 1", o_ready); end
        checks++;
        send_rows(8, 1'b0);
        drain_check(1'b0, "after_areset");
    endtask

    initial begin
        test_reset();
        test_block();
        test_gaps_hold();
        test_back_to_back();
        test_flush_load();
        test_flush_drain();
`ifdef ZIGZAG_CTRL_OVERRUN_EN
        test_overrun();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
